i2c_slave: RTL and testbench

- I2C target (slave) endpoint. It is the responder to the team's I2C master on the same two-wire bus.
- Oversamples SCL/SDA on the local iclk, detects START/STOP, matches a 7-bit address, ACKs, and receives or transmits bytes MSB-first.
- Presents received bytes and requests transmit bytes via single-cycle strobes to local logic.
- Supports standard and fast mode. Requires iclk ≥ 20× SCL.

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_sync_filter.sv | 43 ++++
 rtl/i2c_slave.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, synchronizer depth and ACK/NACK bus levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam int   SYNC_DEPTH = 2;
  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Synchronizes one bus line into iclk, rejects glitches shorter than FILT_LEN samples
// and produces single-cycle rise/fall pulses from the filtered level.
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic [FILT_LEN-1:0]   r_hist;
  logic                  r_filt;
  logic                  r_filt_d;

  // Everything presets to 1 (idle bus level) so reset release never looks like an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '1;
      r_hist   <= '1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_DEPTH-2:0], i_in};
      r_hist   <= {r_hist[FILT_LEN-2:0], r_sync[SYNC_DEPTH-1]};
      if (&r_hist)
        r_filt <= 1'b1;
      else if (~|r_hist)
        r_filt <= 1'b0;
      r_filt_d <= r_filt;
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_filt & ~r_filt_d;
  assign o_fall  = ~r_filt & r_filt_d;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive/transmit MSB-first with single-cycle strobes to local logic.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input  logic       iclk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_shift_in;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       w_tx_req;

  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk(iclk), .i_rst_n(rst), .i_in(scl),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk(iclk), .i_rst_n(rst), .i_in(sda),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start    = w_sda_fall & w_scl_lvl;
  assign w_stop     = w_sda_rise & w_scl_lvl;
  assign w_shift_in = {r_shift[6:0], w_sda_lvl};

  always_comb begin
    // NOTE: every next-state value gets a default up front so no path infers a latch.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = r_busy;
    w_oe_nxt       = r_sda_oe;
    w_rx_valid_nxt = 1'b0;
    w_tx_req       = 1'b0;

    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 4'd0;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_busy_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_IGNORE: w_oe_nxt = 1'b0;
        ST_ADDR: if (w_scl_rise) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_nxt = 4'd0;
            if (w_shift_in[7:1] == SLAVE_ADDR) begin
              w_state_nxt = ST_ADDR_ACK;
              w_rw_nxt    = w_shift_in[0];
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end
        // cnt==0: fall ending bit 8 starts the ACK; cnt==1: fall ending the ACK clock.
        ST_ADDR_ACK, ST_WR_ACK: if (w_scl_fall) begin
          if (r_cnt == 4'd0) begin
            w_oe_nxt  = 1'b1;
            w_cnt_nxt = 4'd1;
          end else begin
            w_cnt_nxt = 4'd0;
            w_oe_nxt  = 1'b0;
            if (r_state == ST_ADDR_ACK && r_rw) begin
              w_tx_req    = 1'b1;
              w_shift_nxt = tx_data;
              w_oe_nxt    = ~tx_data[7];
              w_state_nxt = ST_RD_DATA;
            end else begin
              w_state_nxt = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: if (w_scl_rise) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_nxt      = 4'd0;
            w_rx_data_nxt  = w_shift_in;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = ST_WR_ACK;
          end
        end
        ST_RD_DATA: if (w_scl_fall) begin
          if (r_cnt == 4'd7) begin
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_state_nxt = ST_RD_ACK;
          end else begin
            w_cnt_nxt   = r_cnt + 4'd1;
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_oe_nxt    = ~r_shift[6];
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_lvl == ACK) begin
              w_cnt_nxt = 4'd1;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = ST_IGNORE;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_tx_req    = 1'b1;
            w_shift_nxt = tx_data;
            w_oe_nxt    = ~tx_data[7];
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_RD_DATA;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign tx_req   = w_tx_req;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign rw       = r_rw;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master drives writes, reads,
// repeated start, STOP mid-byte and reset mid-read against hand-computed values.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 10;  // quarter SCL period in iclk cycles (SCL = iclk/40)

  logic       iclk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        sda;
  logic       tx_req, rx_valid, busy, rw;
  logic [7:0] rx_data;

  int errors = 0, checks = 0;
  int n_rxv = 0, n_txr = 0, n_both = 0, n_slave_low = 0;
  int s_rxv, s_txr, s_low;
  logic       ack;
  logic [7:0] rd;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 iclk = ~iclk;

  i2c_slave #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .iclk(iclk), .rst(rst), .scl(scl), .sda(sda),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .rw(rw)
  );

  always @(negedge iclk) begin
    if (rx_valid) n_rxv++;
    if (tx_req) n_txr++;
    if (rx_valid && tx_req) n_both++;
    if (sda === 1'b0 && !m_oe) n_slave_low++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic bit_io(input logic b, output logic r);
    m_oe = ~b; tick(Q);
    scl = 1'b1; tick(Q);
    r = sda; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start;
    m_oe = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    m_oe = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_oe = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    m_oe = 1'b0; tick(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, a);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
  endtask

  initial begin
    tick(3);
    check("rst_sda", sda, 8'h01);
    check("rst_tx_req", tx_req, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 8'h00);
    check("rst_busy", busy, 8'h00);
    check("rst_rw", rw, 8'h00);
    rst = 1'b1;
    tick(4);

    // 1: write 0xA5
    s_rxv = n_rxv;
    i2c_start;
    send_byte(8'hA0, ack);
    check("t1_addr_ack", ack, 8'h00);
    check("t1_busy", busy, 8'h01);
    check("t1_rw", rw, 8'h00);
    send_byte(8'hA5, ack);
    check("t1_data_ack", ack, 8'h00);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_rxv_cnt", 8'(n_rxv - s_rxv), 8'h01);
    i2c_stop;
    check("t1_busy_stop", busy, 8'h00);

    // 2: wrong address 0x51
    s_rxv = n_rxv; s_low = n_slave_low;
    i2c_start;
    send_byte(8'hA2, ack);
    check("t2_addr_nack", ack, 8'h01);
    check("t2_busy", busy, 8'h00);
    send_byte(8'h11, ack);
    check("t2_data_nack", ack, 8'h01);
    i2c_stop;
    check("t2_never_driven", 8'(n_slave_low - s_low), 8'h00);
    check("t2_no_rxv", 8'(n_rxv - s_rxv), 8'h00);
    check("t2_busy_end", busy, 8'h00);

    // 3: read two bytes
    s_txr = n_txr;
    tx_data = 8'h3C;
    i2c_start;
    send_byte(8'hA1, ack);
    check("t3_addr_ack", ack, 8'h00);
    check("t3_rw", rw, 8'h01);
    tx_data = 8'hC3;
    read_byte(rd, 1'b0);
    check("t3_byte0", rd, 8'h3C);
    read_byte(rd, 1'b1);
    check("t3_byte1", rd, 8'hC3);
    check("t3_sda_released", sda, 8'h01);
    check("t3_tx_req_cnt", 8'(n_txr - s_txr), 8'h02);
    i2c_stop;
    check("t3_busy_stop", busy, 8'h00);

    // 4: write 0x07, repeated START, read 0x99
    i2c_start;
    send_byte(8'hA0, ack);
    check("t4_waddr_ack", ack, 8'h00);
    send_byte(8'h07, ack);
    check("t4_wdata_ack", ack, 8'h00);
    check("t4_rx_data", rx_data, 8'h07);
    check("t4_rw_w", rw, 8'h00);
    tx_data = 8'h99;
    i2c_start;
    send_byte(8'hA1, ack);
    check("t4_raddr_ack", ack, 8'h00);
    check("t4_rw_r", rw, 8'h01);
    read_byte(rd, 1'b1);
    check("t4_rd_byte", rd, 8'h99);
    i2c_stop;

    // 5: STOP after four data bits of a write
    s_rxv = n_rxv;
    i2c_start;
    send_byte(8'hA0, ack);
    check("t5_addr_ack", ack, 8'h00);
    bit_io(1'b1, ack);
    bit_io(1'b0, ack);
    bit_io(1'b1, ack);
    bit_io(1'b1, ack);
    i2c_stop;
    check("t5_no_rxv", 8'(n_rxv - s_rxv), 8'h00);
    check("t5_state", 8'(dut.r_state), 8'(ST_IDLE));
    check("t5_sda", sda, 8'h01);
    check("t5_busy", busy, 8'h00);

    // 6: reset while the target drives a 0 in RD_DATA
    tx_data = 8'h3C;
    i2c_start;
    send_byte(8'hA1, ack);
    check("t6_addr_ack", ack, 8'h00);
    check("t6_sda_driven", sda, 8'h00);
    rst = 1'b0;
    #1;
    check("t6_sda_rel", sda, 8'h01);
    check("t6_tx_req", tx_req, 8'h00);
    check("t6_rx_data", rx_data, 8'h00);
    check("t6_rx_valid", rx_valid, 8'h00);
    check("t6_busy", busy, 8'h00);
    check("t6_rw", rw, 8'h00);
    tick(1);
    rst = 1'b1;
    tick(4);
    s_rxv = n_rxv;
    i2c_start;
    send_byte(8'hA0, ack);
    check("t6_w_addr_ack", ack, 8'h00);
    send_byte(8'h5A, ack);
    check("t6_w_data_ack", ack, 8'h00);
    check("t6_rx_data_new", rx_data, 8'h5A);
    check("t6_rxv_cnt", 8'(n_rxv - s_rxv), 8'h01);
    i2c_stop;

    check("no_rxv_txreq_overlap", 8'(n_both), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
